uart_transmitter: RTL and testbench

Serializer stage that sits directly upstream of the UART receive path: accepts parallel bytes over a valid/ready handshake and drives them onto a single serial line as framed characters (start bit, 8 data bits MSB-first, 1 or 2 stop bits). A one-entry holding register lets a producer hand over the next byte while the current one is still being shifted out, giving gap-free back-to-back frames. Bit period is set by a clock-cycle divisor.

---
 rtl/uart_transmitter_if.sv | 8 +
 rtl/uart_transmitter.sv | 92 +++++++++
 tb/tb_uart_transmitter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte handshake between a producer and the UART serializer
interface uart_transmitter_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    modport master (output data_in, data_valid, input data_ready);
    modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: byte-to-serial framer with a one-entry holding register for gap-free frames
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave tx,
    output logic              bit_out,
    output logic              busy,
    output logic              tx_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic stop_idx, stop_idx_n;
    logic [7:0] shift_reg, shift_n, hold, hold_n;
    logic hold_full, hold_full_n;
    logic accept, bit_end, frame_end;
    assign accept = tx.data_valid && tx.data_ready;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign frame_end = bit_end && stop_idx == 1'(STOP_BITS - 1);
    // Next-state and datapath; the holding register drains into the shift register from IDLE or the final stop edge
    always_comb begin
        state_n = state;
        cnt_n = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
        idx_n = idx;
        stop_idx_n = stop_idx;
        shift_n = shift_reg;
        hold_n = accept ? tx.data_in : hold;
        hold_full_n = hold_full || accept;
        case (state)
            IDLE: if (hold_full) begin
                state_n = START;
                shift_n = hold;
                hold_full_n = 1'b0;
            end
            START: if (bit_end) begin
                state_n = DATA;
                idx_n = 3'd7;
            end
            DATA: if (bit_end) begin
                shift_n = {shift_reg[6:0], 1'b0};
                idx_n = idx - 3'd1;
                if (idx == 3'd0) begin
                    state_n = STOP;
                    stop_idx_n = 1'b0;
                end
            end
            STOP: if (bit_end) begin
                stop_idx_n = 1'b1;
                if (frame_end) begin
                    state_n = hold_full ? START : IDLE;
                    if (hold_full) begin
                        shift_n = hold;
                        hold_full_n = 1'b0;
                    end
                end
            end
        endcase
    end
    // State and datapath registers; outputs are registered from next-state values so they align with state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            stop_idx <= 1'b0;
            shift_reg <= '0;
            hold <= '0;
            hold_full <= 1'b0;
            bit_out <= 1'b1;
            busy <= 1'b0;
            tx_done <= 1'b0;
            tx.data_ready <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            stop_idx <= stop_idx_n;
            shift_reg <= shift_n;
            hold <= hold_n;
            hold_full <= hold_full_n;
            bit_out <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[7] : 1'b1;
            busy <= state_n != IDLE || hold_full_n;
            tx_done <= state_n == STOP && stop_idx_n == 1'(STOP_BITS - 1) && cnt_n == CW'(CLKS_PER_BIT - 1);
            tx.data_ready <= !hold_full_n;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of framing, back-to-back handoff, stalls, reset and loopback
module tb_uart_transmitter;
    logic clk, rst, sel, vld;
    logic [7:0] din;
    logic bit_a, busy_a, done_a, bit_b, busy_b, done_b;
    logic bo, bz, dn, rdy;
    logic pre_rdy, pre_busy, pre_bit;
    logic [127:0] cap_bit, cap_done, cap_rdy;
    logic [7:0] q[$];
    logic [7:0] rxq[$];
    logic [1:0] rx_st;
    logic [3:0] rx_n;
    logic [7:0] rx_sh;
    int n_chk, n_fail, base;

    uart_transmitter_if a_if ();
    uart_transmitter_if b_if ();

    uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx(a_if), .bit_out(bit_a), .busy(busy_a), .tx_done(done_a)
    );
    uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx(b_if), .bit_out(bit_b), .busy(busy_b), .tx_done(done_b)
    );

    assign a_if.data_in = din;
    assign b_if.data_in = din;
    assign a_if.data_valid = vld && !sel;
    assign b_if.data_valid = vld && sel;
    assign bo = sel ? bit_b : bit_a;
    assign bz = sel ? busy_b : busy_a;
    assign dn = sel ? done_b : done_a;
    assign rdy = sel ? b_if.data_ready : a_if.data_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference receiver on the CLKS_PER_BIT=1 line: start bit, 8 bits assembled by left shift, stop bit
    always @(negedge clk) begin
        if (rst) begin
            rx_st <= 2'd0;
        end else if (rx_st == 2'd0) begin
            if (!bit_b) begin
                rx_st <= 2'd1;
                rx_n <= 4'd0;
            end
        end else if (rx_st == 2'd1) begin
            rx_sh <= {rx_sh[6:0], bit_b};
            rx_n <= rx_n + 4'd1;
            if (rx_n == 4'd7) rx_st <= 2'd2;
        end else begin
            if (bit_b) rxq.push_back(rx_sh);
            rx_st <= 2'd0;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bit_out"}, bo, 1'b1);
        check({tag, "_ready"}, rdy, 1'b1);
        check({tag, "_busy"}, bz, 1'b0);
        check({tag, "_tx_done"}, dn, 1'b0);
    endtask

    function automatic logic [127:0] push_frame(input logic [127:0] acc, input logic [7:0] d, input int cpb, input int sb);
        logic [127:0] r;
        logic b;
        r = acc;
        for (int i = 0; i < 9 + sb; i++) begin
            b = (i == 0) ? 1'b0 : (i <= 8) ? d[8 - i] : 1'b1;
            for (int c = 0; c < cpb; c++) r = {r[126:0], b};
        end
        return r;
    endfunction

    function automatic logic [127:0] push_ones(input logic [127:0] acc, input int n);
        logic [127:0] r;
        r = acc;
        for (int i = 0; i < n; i++) r = {r[126:0], 1'b1};
        return r;
    endfunction

    function automatic logic [127:0] pulses(input int n, input int p1, input int p2);
        logic [127:0] r;
        r = '0;
        for (int k = 1; k <= n; k++) r = {r[126:0], k == p1 || k == p2};
        return r;
    endfunction

    function automatic logic [127:0] ready_exp(input int n, input int lo, input int mid, input int hi);
        logic [127:0] r;
        r = '0;
        for (int k = 1; k <= n; k++) r = {r[126:0], k <= lo || k == mid || k >= hi};
        return r;
    endfunction

    // Producer feeding q with valid/ready; captures line, tx_done and ready for ncyc cycles after the first accept edge
    task automatic run(input int ncyc, input int offer_at);
        logic last_rdy;
        cap_bit = '0;
        cap_done = '0;
        cap_rdy = '0;
        if (q.size() > 0) begin
            din = q.pop_front();
            vld = 1'b1;
        end
        last_rdy = rdy;
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk);
            if (vld && last_rdy) vld = 1'b0;
            if (k == 0) begin
                pre_rdy = rdy;
                pre_busy = bz;
                pre_bit = bo;
            end else begin
                cap_bit = {cap_bit[126:0], bo};
                cap_done = {cap_done[126:0], dn};
                cap_rdy = {cap_rdy[126:0], rdy};
            end
            if (!vld && q.size() > 0 && k >= offer_at) begin
                din = q.pop_front();
                vld = 1'b1;
            end
            last_rdy = rdy;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        vld = 1'b0;
        din = 8'h00;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle("rst_idle");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        q = '{8'hA5};
        run(44, 0);
        check("single_pre_ready", pre_rdy, 1'b0);
        check("single_pre_busy", pre_busy, 1'b1);
        check("single_pre_bit", pre_bit, 1'b1);
        check("single_bits", cap_bit, push_ones(push_frame('0, 8'hA5, 4, 1), 4));
        check("single_done", cap_done, pulses(44, 40, 0));
        check("single_busy_after", bz, 1'b0);

        q = '{8'h3C, 8'hC3};
        run(82, 10);
        check("b2b_bits", cap_bit, push_ones(push_frame(push_frame('0, 8'h3C, 4, 1), 8'hC3, 4, 1), 2));
        check("b2b_done", cap_done, pulses(82, 40, 80));
        check("b2b_ready", cap_rdy, ready_exp(82, 10, 0, 41));
        check("b2b_busy_after", bz, 1'b0);

        q = '{8'h5A, 8'h11, 8'h22};
        run(122, 0);
        check("stall_bits", cap_bit, push_ones(push_frame(push_frame(push_frame('0, 8'h5A, 4, 1), 8'h11, 4, 1), 8'h22, 4, 1), 2));
        check("stall_ready", cap_rdy, ready_exp(122, 1, 41, 81));
        check("stall_busy_after", bz, 1'b0);

        q = '{8'h96, 8'h69};
        run(15, 3);
        check("mid_data_bit_before_rst", bo, 1'b0);
        vld = 1'b0;
        rst = 1'b1;
        #1;
        check_idle("rst_data");
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        run(30, 0);
        check("post_rst_line", cap_bit, push_ones('0, 30));
        check("post_rst_done", cap_done, '0);
        check("post_rst_busy", bz, 1'b0);

        sel = 1'b1;
        @(negedge clk);
        q = '{8'hFF};
        run(13, 0);
        check("sb2_bits", cap_bit, push_ones(push_frame('0, 8'hFF, 1, 2), 2));
        check("sb2_done", cap_done, pulses(13, 11, 0));
        check("sb2_busy_after", bz, 1'b0);

        base = rxq.size();
        q = '{8'h00, 8'h80, 8'h7E};
        run(36, 0);
        check("loop_count", rxq.size() - base, 3);
        if (rxq.size() >= base + 3) begin
            check("loop_byte0", rxq[base], 8'h00);
            check("loop_byte1", rxq[base + 1], 8'h80);
            check("loop_byte2", rxq[base + 2], 8'h7E);
        end
        check("loop_bits", cap_bit, push_ones(push_frame(push_frame(push_frame('0, 8'h00, 1, 2), 8'h80, 1, 2), 8'h7E, 1, 2), 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
